mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified memory port between the FE instruction-fetch requester and the EX/ME data requester.
- Handles one outstanding transaction at a time. The memory side uses a valid/ready request handshake and a separate response strobe.
- Data requests have priority, with a streak limit so fetch is never starved.
- Emits FE/ME stall signals, and completes hung transactions with a timeout error code.

Parameters:
- ADDR_W, 32, address width
- WORD_W, 32, data width
- COUNT_W, 2, access byte-count code width
- CODE_W, 2, response code width
- WORD_COUNT, 2'd3, count code used for instruction fetches (full word)
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending
- TIMEOUT, 64, WAIT cycles before a forced timeout completion (must be ≥2)

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous, active-high reset
- i_if_req  in  1  fetch request; held until o_if_done
- i_if_addr  in  ADDR_W  fetch address
- o_if_done  out  1  one-cycle fetch completion pulse
- o_if_data  out  WORD_W  fetched word; valid with o_if_done
- o_if_code  out  CODE_W  fetch response code
- i_dm_req  in  1  data request; held until o_dm_done
- i_dm_addr  in  ADDR_W  data address
- i_dm_wr_en  in  1  1 = store, 0 = load
- i_dm_wr_data  in  WORD_W  store data
- i_dm_count  in  COUNT_W  access size code
- o_dm_done  out  1  one-cycle data completion pulse
- o_dm_data  out  WORD_W  load data; valid with o_dm_done
- o_dm_code  out  CODE_W  data response code
- o_fe_stall  out  1  i_if_req & ~o_if_done
- o_me_stall  out  1  i_dm_req & ~o_dm_done
- o_mem_valid  out  1  memory request valid
- i_mem_ready  in  1  memory accepts request
- o_mem_addr  out  ADDR_W  request address
- o_mem_wr_en  out  1  request is a write
- o_mem_wr_data  out  WORD_W  write data
- o_mem_count  out  COUNT_W  size code
- i_mem_rsp_valid  in  1  response strobe
- i_mem_rsp_data  in  WORD_W  read data
- i_mem_rsp_code  in  CODE_W  0 = OK, 1 = ERR

Behaviour:
- Reset (clr high, asynchronous):
  - State goes to IDLE.
  - Streak counter, timeout counter and all registered outputs go to 0.
  - Stall outputs are combinational and follow the requests, since the done signals are 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, grant decision:
  - If i_dm_req and (~i_if_req or streak < MAX_D_STREAK), grant D.
  - Else if i_if_req, grant I.
  - On a grant, latch owner, addr, wr_en, wr_data and count into registers, then go to REQ.
  - For an I grant, latch wr_en = 0, wr_data = 0, count = WORD_COUNT.
- Streak counter:
  - +1 (saturating at MAX_D_STREAK) on a D grant while i_if_req = 1.
  - Cleared on an I grant, or on any IDLE cycle with i_if_req = 0.
- REQ:
  - o_mem_valid = 1, and o_mem_* are driven from the latched registers, stable until accepted.
  - When i_mem_ready = 1, go to WAIT and clear the timeout counter.
- WAIT:
  - Timeout counter +1 per cycle.
  - On i_mem_rsp_valid, latch rsp_data and rsp_code into the owner's data/code outputs, then go to DONE.
  - Otherwise, when the counter reaches TIMEOUT-1, latch data = 0 and code = 2'd2 (TIMEOUT), then go to DONE.
- DONE:
  - The owner's o_x_done = 1 for exactly this cycle. The non-owner's done stays 0.
  - Next state is always IDLE.
  - Data/code outputs hold their values until the next DONE for that port.
- i_mem_rsp_valid outside WAIT is ignored. A late response after a timeout lands in IDLE/REQ and is dropped.
- Zero-wait latency: a request sampled in IDLE at cycle 0 gives REQ in cycle 1, WAIT in cycle 2 and DONE in cycle 3. Back-to-back throughput is one transaction per 4 cycles.
- Requester drops req mid-transaction: the transaction still completes and done still pulses; the requester ignores it.
- New request in the same cycle as DONE: not sampled until IDLE.
- o_mem_valid is 0 in IDLE, WAIT and DONE.
- clr mid-transaction: immediate abort; no done pulse; outputs go to 0.

Test Plan:
- Fetch only, addr 0x100, zero-wait memory returning 0x00500093 → o_mem_valid in cycle 1; o_if_done in cycle 3 with data 0x00500093, code 0; o_fe_stall high in cycles 0–2, low in cycle 3.
- Fetch and store (addr 0x2000, data 0xDEADBEEF, count 3) raised in the same cycle → store issued first with o_mem_wr_en = 1; o_dm_done at cycle 3; fetch o_mem_valid at cycle 5; o_if_done at cycle 7.
- MAX_D_STREAK = 2, fetch held, and data req re-raised each cycle after o_dm_done → grant order is D, D, I, D, D, I.
- i_mem_ready held low for 4 cycles in REQ → o_mem_valid and address 0x40 stay stable all 4 cycles; WAIT is entered only on ready.
- TIMEOUT = 16, memory never responds → DONE after exactly 16 WAIT cycles; o_dm_code = 2, data 0; a response strobe 3 cycles later is ignored and no extra done pulse occurs.
- clr pulsed in WAIT → o_mem_valid and done pulses are 0 immediately (no clock needed); a subsequent response strobe is ignored; after release a fresh fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// One outstanding transaction; data has priority, bounded by a streak limit.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int COUNT_W = 2,
  parameter int CODE_W = 2,
  parameter logic [COUNT_W-1:0] WORD_COUNT = 2'd3,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic clr,
  input  logic i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic o_if_done,
  output logic [WORD_W-1:0] o_if_data,
  output logic [CODE_W-1:0] o_if_code,
  input  logic i_dm_req,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic i_dm_wr_en,
  input  logic [WORD_W-1:0] i_dm_wr_data,
  input  logic [COUNT_W-1:0] i_dm_count,
  output logic o_dm_done,
  output logic [WORD_W-1:0] o_dm_data,
  output logic [CODE_W-1:0] o_dm_code,
  output logic o_fe_stall,
  output logic o_me_stall,
  output logic o_mem_valid,
  input  logic i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic o_mem_wr_en,
  output logic [WORD_W-1:0] o_mem_wr_data,
  output logic [COUNT_W-1:0] o_mem_count,
  input  logic i_mem_rsp_valid,
  input  logic [WORD_W-1:0] i_mem_rsp_data,
  input  logic [CODE_W-1:0] i_mem_rsp_code
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, state_nx;
  logic own_d;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic grant_d, grant_i, tmo;

  assign grant_d = i_dm_req &
    (~i_if_req | (streak < SW'(MAX_D_STREAK)));
  assign grant_i = ~grant_d & i_if_req;
  assign tmo = (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (grant_d | grant_i) state_nx = REQ;
      REQ: if (i_mem_ready) state_nx = WAIT;
      WAIT: if (i_mem_rsp_valid | tmo) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      own_d <= 1'b0;
      streak <= '0;
      tcnt <= '0;
      o_mem_addr <= '0;
      o_mem_wr_en <= 1'b0;
      o_mem_wr_data <= '0;
      o_mem_count <= '0;
      o_if_data <= '0;
      o_if_code <= '0;
      o_dm_data <= '0;
      o_dm_code <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_i || !i_if_req) streak <= '0;
          else if (grant_d && streak != SW'(MAX_D_STREAK))
            streak <= streak + SW'(1);
          if (grant_d) begin
            own_d <= 1'b1;
            o_mem_addr <= i_dm_addr;
            o_mem_wr_en <= i_dm_wr_en;
            o_mem_wr_data <= i_dm_wr_data;
            o_mem_count <= i_dm_count;
          end else if (grant_i) begin
            own_d <= 1'b0;
            o_mem_addr <= i_if_addr;
            o_mem_wr_en <= 1'b0;
            o_mem_wr_data <= '0;
            o_mem_count <= WORD_COUNT;
          end
        end
        REQ: if (i_mem_ready) tcnt <= '0;
        WAIT: begin
          tcnt <= tcnt + TW'(1);
          // A real response wins over a timeout in the same cycle
          if (i_mem_rsp_valid) begin
            if (own_d) begin
              o_dm_data <= i_mem_rsp_data;
              o_dm_code <= i_mem_rsp_code;
            end else begin
              o_if_data <= i_mem_rsp_data;
              o_if_code <= i_mem_rsp_code;
            end
          end else if (tmo) begin
            if (own_d) begin
              o_dm_data <= '0;
              o_dm_code <= CODE_W'(2);
            end else begin
              o_if_data <= '0;
              o_if_code <= CODE_W'(2);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_valid = (state == REQ);
  assign o_if_done = (state == DONE) & ~own_d;
  assign o_dm_done = (state == DONE) & own_d;
  assign o_fe_stall = i_if_req & ~o_if_done;
  assign o_me_stall = i_dm_req & ~o_dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scripted requesters, reactive memory model
// and a completion scoreboard.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic o_if_done;
  logic [31:0] o_if_data;
  logic [1:0] o_if_code;
  logic i_dm_req = 1'b0;
  logic [31:0] i_dm_addr = '0;
  logic i_dm_wr_en = 1'b0;
  logic [31:0] i_dm_wr_data = '0;
  logic [1:0] i_dm_count = '0;
  logic o_dm_done;
  logic [31:0] o_dm_data;
  logic [1:0] o_dm_code;
  logic o_fe_stall, o_me_stall;
  logic o_mem_valid;
  logic i_mem_ready = 1'b0;
  logic [31:0] o_mem_addr;
  logic o_mem_wr_en;
  logic [31:0] o_mem_wr_data;
  logic [1:0] o_mem_count;
  logic i_mem_rsp_valid = 1'b0;
  logic [31:0] i_mem_rsp_data = '0;
  logic [1:0] i_mem_rsp_code = '0;

  mem_arbiter #(.MAX_D_STREAK(2), .TIMEOUT(16)) dut (
    .clk(clk), .clr(clr),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_done(o_if_done), .o_if_data(o_if_data),
    .o_if_code(o_if_code),
    .i_dm_req(i_dm_req), .i_dm_addr(i_dm_addr),
    .i_dm_wr_en(i_dm_wr_en), .i_dm_wr_data(i_dm_wr_data),
    .i_dm_count(i_dm_count),
    .o_dm_done(o_dm_done), .o_dm_data(o_dm_data),
    .o_dm_code(o_dm_code),
    .o_fe_stall(o_fe_stall), .o_me_stall(o_me_stall),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wr_en(o_mem_wr_en),
    .o_mem_wr_data(o_mem_wr_data), .o_mem_count(o_mem_count),
    .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data(i_mem_rsp_data),
    .i_mem_rsp_code(i_mem_rsp_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic [31:0] data;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  int ready_wait = 0;
  int rsp_wait = 0;
  bit rsp_mute = 1'b0;
  int inj_req = 0;
  int inj_ack = 0;
  bit waiting = 1'b0;
  int rcnt = 0;
  int lat = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return a * 32'd3 + 32'h1000_0001;
  endfunction

  task automatic push_exp(input logic d, input logic [31:0] data,
                          input logic [1:0] code);
    exp_q.push_back({d, data, code});
  endtask

  // Memory: ready after ready_wait REQ cycles, response rsp_wait later
  always @(negedge clk) begin
    i_mem_rsp_valid = 1'b0;
    if (clr) begin
      i_mem_ready = 1'b0;
      waiting = 1'b0;
      rcnt = 0;
    end else begin
      if (i_mem_ready) begin
        i_mem_ready = 1'b0;
        waiting = 1'b1;
        lat = 0;
        rcnt = 0;
      end
      if (waiting) begin
        if (rsp_mute) waiting = 1'b0;
        else if (lat >= rsp_wait) begin
          waiting = 1'b0;
          i_mem_rsp_valid = 1'b1;
          i_mem_rsp_data = mem_word(o_mem_addr);
          i_mem_rsp_code = 2'd0;
        end else lat++;
      end else if (o_mem_valid) begin
        if (rcnt >= ready_wait) i_mem_ready = 1'b1;
        else rcnt++;
      end
    end
    if (inj_ack != inj_req) begin
      inj_ack = inj_req;
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data = 32'hBAD0BAD0;
      i_mem_rsp_code = 2'd1;
    end
  end

  // Scoreboard: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (o_if_done || o_dm_done) begin
      checks++;
      if (o_if_done && o_dm_done) begin
        errors++;
        $display("FAIL sb_both_done: both done pulses high");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: done if=%b dm=%b, none expected",
                 o_if_done, o_dm_done);
      end else begin
        e = exp_q.pop_front();
        if (o_dm_done !== e.d) begin
          errors++;
          $display("FAIL sb_owner: got dm=%b required dm=%b",
                   o_dm_done, e.d);
        end else if (e.d) begin
          if (o_dm_data !== e.data || o_dm_code !== e.code) begin
            errors++;
            $display("FAIL sb_dm: got %h/%0d required %h/%0d",
                     o_dm_data, o_dm_code, e.data, e.code);
          end
        end else if (o_if_data !== e.data || o_if_code !== e.code) begin
          errors++;
          $display("FAIL sb_if: got %h/%0d required %h/%0d",
                   o_if_data, o_if_code, e.data, e.code);
        end
      end
    end
  end

  task automatic test_reset();
    #2 clr = 1'b1;
    i_if_req = 1'b1;
    #1;
    checks++;
    if (o_fe_stall !== 1'b1 || o_me_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: fe=%b me=%b required 1/0",
               o_fe_stall, o_me_stall);
    end
    i_if_req = 1'b0;
    #1;
    checks++;
    if ({o_mem_valid, o_if_done, o_dm_done, o_fe_stall} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: valid=%b ifd=%b dmd=%b fes=%b required 0",
               o_mem_valid, o_if_done, o_dm_done, o_fe_stall);
    end
    checks++;
    if (o_if_data !== 0 || o_dm_data !== 0 || o_if_code !== 0 ||
        o_dm_code !== 0 || o_mem_addr !== 0 || o_mem_wr_en !== 0 ||
        o_mem_wr_data !== 0 || o_mem_count !== 0) begin
      errors++;
      $display("FAIL reset_regs: ifd=%h dmd=%h addr=%h cnt=%0d required 0",
               o_if_data, o_dm_data, o_mem_addr, o_mem_count);
    end
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    push_exp(1'b0, 32'h00500093, 2'd0);
    i_if_addr = 32'h100;
    i_if_req = 1'b1;
    #1;
    checks++;
    if (o_fe_stall !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall0: fe_stall=%b required 1", o_fe_stall);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (o_mem_valid !== (c == 1)) begin
        errors++;
        $display("FAIL fetch_valid c%0d: got %b required %b",
                 c, o_mem_valid, (c == 1));
      end
      checks++;
      if (o_if_done !== (c == 3) || o_fe_stall !== (c != 3)) begin
        errors++;
        $display("FAIL fetch_done c%0d: done=%b stall=%b", c,
                 o_if_done, o_fe_stall);
      end
    end
    checks++;
    if (o_if_data !== 32'h00500093 || o_if_code !== 2'd0) begin
      errors++;
      $display("FAIL fetch_data: got %h/%0d required 00500093/0",
               o_if_data, o_if_code);
    end
    i_if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_priority();
    push_exp(1'b1, mem_word(32'h2000), 2'd0);
    push_exp(1'b0, mem_word(32'h104), 2'd0);
    i_if_addr = 32'h104;
    i_if_req = 1'b1;
    i_dm_addr = 32'h2000;
    i_dm_wr_en = 1'b1;
    i_dm_wr_data = 32'hDEADBEEF;
    i_dm_count = 2'd3;
    i_dm_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (o_mem_valid !== (c == 1 || c == 5)) begin
        errors++;
        $display("FAIL prio_valid c%0d: got %b", c, o_mem_valid);
      end
      if (c == 1) begin
        checks++;
        if (o_mem_wr_en !== 1'b1 || o_mem_addr !== 32'h2000 ||
            o_mem_wr_data !== 32'hDEADBEEF || o_mem_count !== 2'd3) begin
          errors++;
          $display("FAIL prio_store: we=%b addr=%h wd=%h cnt=%0d",
                   o_mem_wr_en, o_mem_addr, o_mem_wr_data, o_mem_count);
        end
      end
      if (c == 3) begin
        checks++;
        if (o_dm_done !== 1'b1 || o_me_stall !== 1'b0) begin
          errors++;
          $display("FAIL prio_dm_done: done=%b stall=%b required 1/0",
                   o_dm_done, o_me_stall);
        end
        i_dm_req = 1'b0;
      end
      if (c == 5) begin
        checks++;
        if (o_mem_wr_en !== 1'b0 || o_mem_addr !== 32'h104 ||
            o_mem_wr_data !== 32'h0 || o_mem_count !== 2'd3) begin
          errors++;
          $display("FAIL prio_fetch: we=%b addr=%h wd=%h cnt=%0d",
                   o_mem_wr_en, o_mem_addr, o_mem_wr_data, o_mem_count);
        end
      end
      if (c == 7) begin
        checks++;
        if (o_if_done !== 1'b1) begin
          errors++;
          $display("FAIL prio_if_done: got %b required 1", o_if_done);
        end
        i_if_req = 1'b0;
      end
    end
    i_dm_wr_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_streak();
    logic ord [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int n = 0;
    for (int k = 0; k < 6; k++)
      push_exp(ord[k], ord[k] ? mem_word(32'h3000) : mem_word(32'h200),
               2'd0);
    i_if_addr = 32'h200;
    i_dm_addr = 32'h3000;
    i_dm_count = 2'd2;
    i_if_req = 1'b1;
    i_dm_req = 1'b1;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (o_if_done || o_dm_done) begin
        checks++;
        if (o_dm_done !== ord[n]) begin
          errors++;
          $display("FAIL streak_order #%0d: dm=%b required %b",
                   n, o_dm_done, ord[n]);
        end
        n++;
      end
    end
    i_if_req = 1'b0;
    i_dm_req = 1'b0;
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL streak_count: got %0d completions required 6", n);
    end
    @(negedge clk);
  endtask

  task automatic test_ready_stall();
    ready_wait = 4;
    push_exp(1'b1, mem_word(32'h40), 2'd0);
    i_dm_addr = 32'h40;
    i_dm_count = 2'd1;
    i_dm_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (o_mem_valid !== (c <= 5) ||
          (c <= 5 && o_mem_addr !== 32'h40)) begin
        errors++;
        $display("FAIL stall_req c%0d: valid=%b addr=%h", c,
                 o_mem_valid, o_mem_addr);
      end
      checks++;
      if (o_dm_done !== (c == 7)) begin
        errors++;
        $display("FAIL stall_done c%0d: got %b required %b", c,
                 o_dm_done, (c == 7));
      end
    end
    i_dm_req = 1'b0;
    ready_wait = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    rsp_mute = 1'b1;
    push_exp(1'b1, 32'h0, 2'd2);
    i_dm_addr = 32'h80;
    i_dm_wr_en = 1'b1;
    i_dm_wr_data = 32'h12345678;
    i_dm_count = 2'd3;
    i_dm_req = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      checks++;
      if (o_dm_done !== (c == 18) || o_mem_valid !== (c == 1)) begin
        errors++;
        $display("FAIL tmo_cycle c%0d: done=%b valid=%b", c,
                 o_dm_done, o_mem_valid);
      end
    end
    checks++;
    if (o_dm_data !== 32'h0 || o_dm_code !== 2'd2) begin
      errors++;
      $display("FAIL tmo_code: got %h/%0d required 0/2",
               o_dm_data, o_dm_code);
    end
    i_dm_req = 1'b0;
    i_dm_wr_en = 1'b0;
    rsp_mute = 1'b0;
    repeat (2) @(negedge clk);
    inj_req++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (o_dm_done !== 1'b0 || o_if_done !== 1'b0 ||
          o_dm_code !== 2'd2 || o_dm_data !== 32'h0) begin
        errors++;
        $display("FAIL tmo_late: done=%b/%b code=%0d data=%h",
                 o_if_done, o_dm_done, o_dm_code, o_dm_data);
      end
    end
  endtask

  task automatic test_clr_abort();
    rsp_wait = 5;
    i_if_addr = 32'h300;
    i_if_req = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (o_mem_valid !== 1'b0 || o_if_done !== 1'b0 ||
        o_dm_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_ctl: valid=%b ifd=%b dmd=%b required 0",
               o_mem_valid, o_if_done, o_dm_done);
    end
    checks++;
    if (o_dm_code !== 2'd0 || o_mem_addr !== 32'h0 ||
        o_fe_stall !== 1'b1) begin
      errors++;
      $display("FAIL clr_regs: code=%0d addr=%h fes=%b required 0/0/1",
               o_dm_code, o_mem_addr, o_fe_stall);
    end
    i_if_req = 1'b0;
    rsp_wait = 0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    inj_req++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (o_if_done !== 1'b0 || o_mem_valid !== 1'b0) begin
        errors++;
        $display("FAIL clr_late: done=%b valid=%b required 0",
                 o_if_done, o_mem_valid);
      end
    end
    push_exp(1'b0, 32'h00500093, 2'd0);
    i_if_addr = 32'h100;
    i_if_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_if_done !== 1'b1 || o_if_data !== 32'h00500093) begin
      errors++;
      $display("FAIL clr_refetch: done=%b data=%h required 1/00500093",
               o_if_done, o_if_data);
    end
    i_if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_streak();
    test_ready_stall();
    test_timeout();
    test_clr_abort();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_pending: %0d completions missing required 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
